noise_seq_loader: RTL and testbench
===================================

Name: noise_seq_loader

Overview:
- Host-side writer for the noise-measurement sequencer's load interface (nload / nchoice / ndatain) and its start/interrupt handshake.
- Host software programs NSEG segment durations into shadow registers, then pulses go.
- Block serialises each 20-bit duration into two 16-bit words on the load bus, pulses noisestart, and waits for the active-low interrupt.
- Reports done, or timeout if interrupt never arrives.

Parameters:
NSEG, 6, number of sequencer segments loaded per run (1..8)
TW, 20, segment duration width in clk_sys cycles
TMO_CYC, 2000000, max cycles from noisestart to interrupt before timeout_err

Ports:
clk_sys  in  1  system clock, all logic rising-edge
noiserst  in  1  synchronous reset, active-high
cfg_we  in  1  shadow register write strobe
cfg_addr  in  3  segment index for cfg_we (values >= NSEG ignored)
cfg_data  in  TW  segment duration for cfg_we
go  in  1  one-cycle start request
interrupt  in  1  sequencer state_over_n, active-low completion
ndatain  out  16  load data word
nchoice  out  1  word select: 0 = low word, 1 = high word
nload  out  1  one-cycle load strobe
noisestart  out  1  one-cycle sequencer start pulse
busy  out  1  high from go acceptance until done/timeout pulse cycle inclusive
done  out  1  one-cycle pulse on interrupt received
timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: all outputs 0; state IDLE; shadow regs, segment index, word flag, timeout counter cleared. Reset in any state aborts immediately; no further nload or noisestart is issued.
- Shadow regs: dur[k] <= cfg_data on cfg_we when cfg_addr < NSEG and state == IDLE. Writes while busy are dropped.
- Word format, segment k:
  - low word: nchoice=0, ndatain=dur[k][15:0]
  - high word: nchoice=1, ndatain[15:13]=k, [12:4]=0, [3:0]=dur[k][19:16]
- Order: seg 0 low, seg 0 high, seg 1 low, …, seg NSEG-1 high.
- States:
  - IDLE: go=1 -> SETUP, busy=1 from the next cycle; seg=0, word=0. go is ignored outside IDLE.
  - SETUP: drive ndatain/nchoice; nload=0 -> STROBE.
  - STROBE: same data; nload=1 for exactly 1 cycle -> HOLD.
  - HOLD: same data; nload=0. If word=0: word<=1 -> SETUP. Else if seg < NSEG-1: seg++, word<=0 -> SETUP. Else -> START.
  - START: noisestart=1 for 1 cycle; clear timeout counter; armed<=0 -> WAIT.
  - WAIT: armed<=1 once interrupt==1 is sampled. If armed and interrupt==0 -> DONE. If counter reaches TMO_CYC-1 -> TMO. Timeout is checked first when both occur in the same cycle.
  - DONE: done=1 for 1 cycle, busy=1 -> IDLE.
  - TMO: timeout_err=1 for 1 cycle, busy=1 -> IDLE.
- Each word occupies exactly 3 cycles; data is stable one cycle before and one cycle after nload.
  - Load phase = 6*NSEG cycles.
  - noisestart asserts on cycle 6*NSEG+1 after go.
- Outside SETUP/STROBE/HOLD: ndatain=0, nchoice=0.
- interrupt already low at START is not completion; arming requires a high sample first (stale state_over_n).
- dur=0 is loaded like any other value, with no special casing.
- Counter width: ceil(log2(TMO_CYC))+1; it saturates and does not wrap.

Test Plan:
- Reset, then write dur[0]=0x12345, dur[5]=0xABCDE, pulse go -> 12 nload pulses, 3 cycles apart. Word 1 = 0x2345/nchoice 0. Word 2 = 0x0001/nchoice 1. Word 12 = 0xA00A/nchoice 1. Other segments load 0x0000 / k<<13. noisestart at cycle 37.
- After noisestart, hold interrupt=1 for 50 cycles, then 0 -> done pulse 1 cycle later, busy falls the following cycle.
- Hold interrupt=0 throughout the run (stale) -> no done; timeout_err pulses at TMO_CYC (bench: TMO_CYC=100).
- Issue cfg_we dur[0]=0xFFFFF and a second go during the load phase -> both ignored; the loaded word stays at the old value; only one noisestart.
- Assert noiserst during STROBE of seg 2 -> next cycle nload=0, busy=0, outputs 0, shadow regs 0; no noisestart afterwards.
- cfg_addr=7 with NSEG=6 -> no register changes; run loads previous values.

Source files
------------

// File: rtl/noise_seq_loader_if.sv
// Host and sequencer load-bus signals of the noise sequencer loader.
// The slave modport is the loader's view; the master modport is the driver's view.
interface noise_seq_loader_if #(
    parameter int TW = 20
);
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [TW-1:0] cfg_data;
    logic          go;
    logic          interrupt;
    logic [15:0]   ndatain;
    logic          nchoice;
    logic          nload;
    logic          noisestart;
    logic          busy;
    logic          done;
    logic          timeout_err;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, go, interrupt,
        output ndatain, nchoice, nload, noisestart, busy, done, timeout_err
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, go, interrupt,
        input  ndatain, nchoice, nload, noisestart, busy, done, timeout_err
    );
endinterface

// File: rtl/noise_seq_loader.sv
// Serialises NSEG shadowed segment durations onto the sequencer load bus,
// then starts the sequencer and waits for its active-low completion interrupt.
module noise_seq_loader #(
    parameter int NSEG    = 6,
    parameter int TW      = 20,
    parameter int TMO_CYC = 2000000
) (
    input  logic               clk_sys,
    input  logic               noiserst,
    noise_seq_loader_if.slave  bus
);
    localparam int             CW       = $clog2(TMO_CYC) + 1;
    localparam logic [3:0]     NSEG_W   = 4'(NSEG);
    localparam logic [2:0]     LAST_SEG = 3'(NSEG - 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6,
        S_TMO    = 3'd7
    } state_t;

    state_t        r_state;
    logic [2:0]    r_seg;
    logic          r_word;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_dur [8];

    logic [15:0]   r_ndatain;
    logic          r_nchoice;
    logic          r_nload;
    logic          r_noisestart;
    logic          r_busy;
    logic          r_done;
    logic          r_tmo;

    state_t        w_state_nxt;
    logic [2:0]    w_seg_nxt;
    logic          w_word_nxt;
    logic          w_armed_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_wr_en;
    logic [TW-1:0] w_dur_nxt [8];
    logic [TW-1:0] w_dur_sel;
    logic [3:0]    w_hi_nib;

    logic [15:0]   w_ndatain_nxt;
    logic          w_nchoice_nxt;
    logic          w_nload_nxt;
    logic          w_noisestart_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_tmo_nxt;

    // Shadow writes are only taken while idle and for implemented segments.
    assign w_wr_en   = bus.cfg_we && (r_state == S_IDLE) && ({1'b0, bus.cfg_addr} < NSEG_W);
    assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : (r_cnt + CNT_ONE);

    // Next value of the shadow duration registers.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_dur_nxt[i] = (w_wr_en && (bus.cfg_addr == 3'(i))) ? bus.cfg_data : r_dur[i];
        end
    end

    // Shadow duration register bank.
    always_ff @(posedge clk_sys) begin
        if (noiserst) begin
            for (int i = 0; i < 8; i++) begin
                r_dur[i] <= '0;
            end
        end else begin
            r_dur <= w_dur_nxt;
        end
    end

    // State register with sequencing context (segment, word, arm flag, timeout counter).
    always_ff @(posedge clk_sys) begin
        if (noiserst) begin
            r_state <= S_IDLE;
            r_seg   <= 3'd0;
            r_word  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
            r_word  <= w_word_nxt;
            r_armed <= w_armed_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_seg_nxt   = r_seg;
        w_word_nxt  = r_word;
        w_armed_nxt = r_armed;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_state_nxt = S_SETUP;
                    w_seg_nxt   = 3'd0;
                    w_word_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (!r_word) begin
                    w_word_nxt  = 1'b1;
                    w_state_nxt = S_SETUP;
                end else if (r_seg < LAST_SEG) begin
                    w_seg_nxt   = r_seg + 3'd1;
                    w_word_nxt  = 1'b0;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_armed_nxt = 1'b0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus.interrupt) begin
                    w_armed_nxt = 1'b1;
                end else begin
                    w_armed_nxt = r_armed;
                end
                // A stale low interrupt never completes: completion needs a prior high sample.
                if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_TMO;
                end else if (r_armed && !bus.interrupt) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_TMO:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_dur_sel = w_dur_nxt[w_seg_nxt];
    assign w_hi_nib  = 4'(w_dur_sel >> 16);

    // Output decode from the upcoming state so that the registered outputs track it.
    always_comb begin
        w_ndatain_nxt    = 16'd0;
        w_nchoice_nxt    = 1'b0;
        w_nload_nxt      = 1'b0;
        w_noisestart_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_tmo_nxt        = 1'b0;
        case (w_state_nxt)
            S_SETUP, S_STROBE, S_HOLD: begin
                w_busy_nxt    = 1'b1;
                w_nload_nxt   = (w_state_nxt == S_STROBE);
                w_nchoice_nxt = w_word_nxt;
                if (w_word_nxt) begin
                    w_ndatain_nxt = {w_seg_nxt, 9'd0, w_hi_nib};
                end else begin
                    w_ndatain_nxt = w_dur_sel[15:0];
                end
            end
            S_START: begin
                w_busy_nxt       = 1'b1;
                w_noisestart_nxt = 1'b1;
            end
            S_WAIT: w_busy_nxt = 1'b1;
            S_DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            S_TMO: begin
                w_busy_nxt = 1'b1;
                w_tmo_nxt  = 1'b1;
            end
            S_IDLE:  w_busy_nxt = 1'b0;
            default: w_busy_nxt = 1'b0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk_sys) begin
        if (noiserst) begin
            r_ndatain    <= 16'd0;
            r_nchoice    <= 1'b0;
            r_nload      <= 1'b0;
            r_noisestart <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_ndatain    <= w_ndatain_nxt;
            r_nchoice    <= w_nchoice_nxt;
            r_nload      <= w_nload_nxt;
            r_noisestart <= w_noisestart_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_tmo        <= w_tmo_nxt;
        end
    end

    assign bus.ndatain     = r_ndatain;
    assign bus.nchoice     = r_nchoice;
    assign bus.nload       = r_nload;
    assign bus.noisestart  = r_noisestart;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_tmo;
endmodule

// File: tb/tb_noise_seq_loader.sv
// Scoreboard bench for noise_seq_loader: stimulus queues expected bus events,
// a negedge monitor pops and compares each nload/noisestart/done/timeout_err.
module tb_noise_seq_loader;
    localparam int TMO = 100;

    typedef struct {
        int          kind;   // 0 load, 1 noisestart, 2 done, 3 timeout
        logic [15:0] data;
        logic        ch;
        int          at;
    } ev_t;

    logic clk_sys = 1'b0;
    logic noiserst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  q[$];
    logic [19:0] exp_dur [6];

    noise_seq_loader_if #(.TW(20)) bus ();

    noise_seq_loader #(.NSEG(6), .TW(20), .TMO_CYC(TMO)) dut (
        .clk_sys  (clk_sys),
        .noiserst (noiserst),
        .bus      (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic sb_check(input int kind, input logic [15:0] d, input logic c);
        ev_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind %0d data %h ch %b at cyc %0d, expected no event",
                     kind, d, c, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.at != cyc || (kind == 0 && (e.data !== d || e.ch !== c))) begin
                n_fail++;
                $display("FAIL sb_event: got kind %0d cyc %0d data %h ch %b, expected kind %0d cyc %0d data %h ch %b",
                         kind, cyc, d, c, e.kind, e.at, e.data, e.ch);
            end
        end
    endtask

    // Monitor: compares every output event against the head of the queue.
    always @(negedge clk_sys) begin
        if (bus.nload)       sb_check(0, bus.ndatain, bus.nchoice);
        if (bus.noisestart)  sb_check(1, 16'd0, 1'b0);
        if (bus.done)        sb_check(2, 16'd0, 1'b0);
        if (bus.timeout_err) sb_check(3, 16'd0, 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push(input int kind, input logic [15:0] d, input logic c, input int at);
        ev_t e;
        e.kind = kind; e.data = d; e.ch = c; e.at = at;
        q.push_back(e);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [19:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    // Pulses go and queues the 12 words plus noisestart; s = noisestart cycle.
    task automatic start_run(output int k, output int s);
        k = cyc;
        bus.go = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j % 2 == 0)
                push(0, exp_dur[j/2][15:0], 1'b0, k + 2 + 3*j);
            else
                push(0, {3'(j/2), 9'd0, exp_dur[j/2][19:16]}, 1'b1, k + 2 + 3*j);
        end
        s = k + 37;
        push(1, 16'd0, 1'b0, s);
        tick(1);
        bus.go = 1'b0;
        chk("busy_after_go", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic finish_done(input int t);
        int m;
        tick_to(t);
        bus.interrupt = 1'b0;
        m = cyc;
        push(2, 16'd0, 1'b0, m + 1);
        tick(1);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
        tick(1);
        chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
        bus.interrupt = 1'b1;
    endtask

    initial begin
        int k, s;
        noiserst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_data = 20'd0;
        bus.go = 1'b0; bus.interrupt = 1'b1;
        for (int i = 0; i < 6; i++) exp_dur[i] = 20'd0;
        tick(3);
        noiserst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_nload", {31'd0, bus.nload}, 32'd0);
        chk("rst_ndatain", {16'd0, bus.ndatain}, 32'd0);
        chk("rst_flags", {29'd0, bus.noisestart, bus.done, bus.timeout_err}, 32'd0);

        // Run 1: basic load, completion after 50 high interrupt cycles.
        cfg_write(3'd0, 20'h12345); exp_dur[0] = 20'h12345;
        cfg_write(3'd5, 20'hABCDE); exp_dur[5] = 20'hABCDE;
        start_run(k, s);
        finish_done(s + 50);

        // Run 2: cfg write and second go during the load phase are ignored.
        start_run(k, s);
        tick(3);
        cfg_write(3'd0, 20'hFFFFF);
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        finish_done(s + 5);

        // Run 3: interrupt stuck low (stale) -> timeout; also shows dur[0] kept.
        bus.interrupt = 1'b0;
        start_run(k, s);
        push(3, 16'd0, 1'b0, s + TMO + 1);
        tick_to(s + TMO + 1);
        chk("busy_in_tmo", {31'd0, bus.busy}, 32'd1);
        tick(1);
        chk("busy_after_tmo", {31'd0, bus.busy}, 32'd0);
        bus.interrupt = 1'b1;
        tick(2);

        // Run 4: reset during STROBE of segment 2 (word 5 strobe at k+14).
        start_run(k, s);
        tick_to(k + 14);
        noiserst = 1'b1;
        tick(1);
        noiserst = 1'b0;
        chk("abort_nload", {31'd0, bus.nload}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_data", {15'd0, bus.nchoice, bus.ndatain}, 32'd0);
        chk("abort_pending", 32'(q.size()), 32'd8);
        q.delete();
        for (int i = 0; i < 6; i++) exp_dur[i] = 20'd0;
        tick(60);

        // Run 5: out-of-range address ignored; shadow regs were cleared by reset.
        cfg_write(3'd3, 20'h0F00F); exp_dur[3] = 20'h0F00F;
        cfg_write(3'd7, 20'hFFFFF);
        start_run(k, s);
        finish_done(s + 10);
        tick(5);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
